// File: rtl/booth_divider_if.sv
// booth_divider_if
//   Request/Done handshake bundle shared by the arithmetic unit's sequential
//   multiplier and divider.
//   master : drives Request/Dividend/Divisor, observes results and Done
//   slave  : the divider side, consumes operands and produces results
//   Parameter N_LEN sets operand/result width and must match the divider.
interface booth_divider_if #(
    parameter int N_LEN = 8
);
    logic             Request;
    logic [N_LEN-1:0] Dividend;
    logic [N_LEN-1:0] Divisor;
    logic [N_LEN-1:0] Quotient;
    logic [N_LEN-1:0] Remainder;
    logic             DivByZero;
    logic             Done;

    modport master (
        output Request, Dividend, Divisor,
        input  Quotient, Remainder, DivByZero, Done
    );

    modport slave (
        input  Request, Dividend, Divisor,
        output Quotient, Remainder, DivByZero, Done
    );
endinterface

// File: rtl/booth_divider.sv
// booth_divider
//   Sequential signed two's-complement divider. Runs radix-2 restoring
//   division on operand magnitudes, one quotient bit per clock, then applies
//   sign correction (quotient truncates toward zero, remainder follows the
//   dividend's sign).
// Ports
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset, aborts any operation in flight
//   bus   : booth_divider_if.slave (Request, Dividend, Divisor in;
//           Quotient, Remainder, DivByZero, Done out)
// Optional build macro
//   DIVIDER_EARLY_EXIT_EN : when defined, an operation whose divisor magnitude
//   exceeds the dividend magnitude finishes straight from PREP.
module booth_divider #(
    parameter int N_LEN = 8
) (
    input logic           Clock,
    input logic           Reset,
    booth_divider_if.slave bus
);
    localparam int CW = $clog2(N_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [N_LEN-1:0] dividend_q,  dividend_d;
    logic [N_LEN-1:0] divisor_q,   divisor_d;
    logic [N_LEN:0]   rem_q,       rem_d;
    logic [N_LEN-1:0] quo_sh_q,    quo_sh_d;
    logic [N_LEN-1:0] dmag_q,      dmag_d;
    logic             quo_neg_q,   quo_neg_d;
    logic             rem_neg_q,   rem_neg_d;
    logic [N_LEN-1:0] quotient_q,  quotient_d;
    logic [N_LEN-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // Magnitudes of the latched operands; the most negative value negates to
    // itself, which read as unsigned is exactly its magnitude.
    logic [N_LEN-1:0] dvd_mag;
    logic [N_LEN-1:0] dvs_mag;
    assign dvd_mag = dividend_q[N_LEN-1] ? (~dividend_q + 1'b1) : dividend_q;
    assign dvs_mag = divisor_q[N_LEN-1]  ? (~divisor_q  + 1'b1) : divisor_q;

    // One restoring step: shift {R,Q} left and trial-subtract the divisor.
    // R never exceeds 2*|Divisor|-1, so the top bit of the difference is a
    // reliable borrow/negative indicator.
    logic [N_LEN:0]   shifted_r;
    logic [N_LEN-1:0] shifted_q;
    logic [N_LEN:0]   trial;
    assign shifted_r = {rem_q[N_LEN-1:0], quo_sh_q[N_LEN-1]};
    assign shifted_q = {quo_sh_q[N_LEN-2:0], 1'b0};
    assign trial     = shifted_r - {1'b0, dmag_q};

    // State and datapath registers; reset clears everything so an aborted
    // operation leaves no partial results behind.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_sh_q    <= '0;
            dmag_q      <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_sh_q    <= quo_sh_d;
            dmag_q      <= dmag_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state and datapath control. Results only change in PREP (early
    // finishes) and FIX, so they hold between operations.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_sh_d    = quo_sh_q;
        dmag_d      = dmag_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.Request) begin
                    dividend_d = bus.Dividend;
                    divisor_d  = bus.Divisor;
                    state_d    = PREP;
                end
            end

            PREP: begin
                quo_neg_d = dividend_q[N_LEN-1] ^ divisor_q[N_LEN-1];
                rem_neg_d = dividend_q[N_LEN-1];
                rem_d     = '0;
                quo_sh_d  = dvd_mag;
                dmag_d    = dvs_mag;
                cnt_d     = '0;
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                    state_d     = IDLE;
                end
`ifdef DIVIDER_EARLY_EXIT_EN
                else if (dvs_mag > dvd_mag) begin
                    quotient_d  = '0;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b0;
                    state_d     = IDLE;
                end
`endif
                else begin
                    state_d = ITER;
                end
            end

            ITER: begin
                if (!trial[N_LEN]) begin
                    rem_d    = trial;
                    quo_sh_d = shifted_q | {{(N_LEN-1){1'b0}}, 1'b1};
                end else begin
                    rem_d    = shifted_r;
                    quo_sh_d = shifted_q;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_LEN-1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quotient_d  = quo_neg_q ? (~quo_sh_q + 1'b1) : quo_sh_q;
                remainder_d = rem_neg_q ? (~rem_q[N_LEN-1:0] + 1'b1)
                                        : rem_q[N_LEN-1:0];
                dbz_d       = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Done      = (state_q == IDLE);
    assign bus.Quotient  = quotient_q;
    assign bus.Remainder = remainder_q;
    assign bus.DivByZero = dbz_q;
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed two's-complement divider for the arithmetic unit. It is the inverse companion of the Booth multiplier and sits beside it on the same Request/Done handshake.
- Radix-2 restoring division runs on operand magnitudes, one quotient bit per cycle. The result then gets a sign correction.
- Control FSM and datapath (remainder/quotient shift register, subtractor, iteration counter) are contained in this one module.

Parameters:
- N_LEN, 8, operand and result width in bits; must be >= 2.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Request  input  1  start request; sampled only in IDLE.
- Dividend  input  N_LEN  signed dividend; sampled on the accepting edge.
- Divisor  input  N_LEN  signed divisor; sampled on the accepting edge.
- Quotient  output  N_LEN  signed quotient, registered.
- Remainder  output  N_LEN  signed remainder, registered.
- DivByZero  output  1  registered flag: last operation had Divisor == 0.
- Done  output  1  high exactly when the FSM is in IDLE; combinational decode of the state.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Reset behaviour:
  - Reset high at a rising edge forces state IDLE, counter 0, Quotient 0, Remainder 0, DivByZero 0; Done = 1.
  - Reset during any state, including mid-iteration, aborts the operation. Outputs are cleared, not left partially updated.
- States:
  - IDLE: Done = 1. If Request = 1, latch Dividend/Divisor, go to PREP.
  - PREP:
    - Compute magnitudes |Dividend| and |Divisor| as N_LEN-bit unsigned values; |-2^(N_LEN-1)| = 2^(N_LEN-1) fits unsigned.
    - Record sign_q = sign(Dividend) XOR sign(Divisor) and sign_r = sign(Dividend).
    - Clear the partial remainder and the counter.
    - If Divisor == 0: write Quotient = all ones, Remainder = latched Dividend, DivByZero = 1, go to IDLE.
    - Otherwise go to ITER.
  - ITER: one restoring step per cycle.
    - Shift {R, Q} left by 1. R is N_LEN+1 bits.
    - T = R - {0, |Divisor|}. If T >= 0, R = T and Q[0] = 1; else Q[0] = 0.
    - counter increments. When counter == N_LEN-1, go to FIX; else stay in ITER.
  - FIX:
    - Quotient = sign_q ? -Q : Q, truncated to N_LEN bits.
    - Remainder = sign_r ? -R : R, truncated to N_LEN bits.
    - DivByZero = 0. Go to IDLE.
  - Illegal state encodings go to IDLE on the next edge.
- Latency, measured from the edge where Request is accepted to the edge where outputs update and Done rises:
  - Normal case: N_LEN+3 edges (11 for N_LEN = 8).
  - Divide by zero: 2 edges.
- Handshake:
  - Request is ignored outside IDLE.
  - Request held high continuously starts a new operation on the first edge in IDLE, so Done is high for exactly one cycle between back-to-back operations.
  - Dividend/Divisor may change after the accepting edge without effect.
  - Quotient/Remainder/DivByZero hold their values until the FIX or PREP write of the next operation.
- Rounding and overflow:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend. The identity Dividend = Quotient*Divisor + Remainder holds.
  - Overflow case -2^(N_LEN-1) / -1 gives Quotient = -2^(N_LEN-1) (wraps) and Remainder = 0. No flag is raised.
- Counter width: $clog2(N_LEN) bits, unsigned.

Optional Feature:
- Macro: DIVIDER_EARLY_EXIT_EN.
- With the macro defined:
  - In PREP, if |Divisor| > |Dividend| and Divisor != 0: write Quotient = 0, Remainder = latched Dividend, DivByZero = 0, go directly to IDLE.
  - Latency is 2 edges.
  - The divide-by-zero check takes priority over the early exit.
- Without the macro: every non-zero-divisor operation runs all N_LEN ITER cycles. Results are identical; only latency differs.

Test Plan:
1. Dividend = 100, Divisor = 7, Request pulsed -> Done low for 10 cycles, then high; Quotient = 14, Remainder = 2, DivByZero = 0.
2. Sign cases:
   - (-100)/7 -> Quotient = -14 (0xF2), Remainder = -2 (0xFE).
   - 100/(-7) -> Quotient = -14, Remainder = 2.
   - (-100)/(-7) -> Quotient = 14, Remainder = -2.
3. Dividend = -128 (0x80), Divisor = -1 -> Quotient = 0x80, Remainder = 0. Also Dividend = -128, Divisor = 1 -> Quotient = 0x80, Remainder = 0.
4. Dividend = 5, Divisor = 0 -> Done back high after 2 edges; Quotient = 0xFF, Remainder = 5, DivByZero = 1. A following 9/3 clears DivByZero and gives Quotient = 3, Remainder = 0.
5. Reset asserted during the 4th ITER cycle of 100/7 -> next edge: Done = 1, Quotient = 0, Remainder = 0. Request held high throughout -> new operation accepted on the first edge after Reset deasserts.
6. Dividend = 3, Divisor = 9 -> Quotient = 0, Remainder = 3. Latency is 11 edges without DIVIDER_EARLY_EXIT_EN and 2 edges with it.
